// File: rtl/hermes_sender.sv
// hermes_sender: serialises one packet descriptor (header and size) followed
// by a streamed payload onto a credit-based flit link.
// Optional feature: define HERMES_SENDER_STATS_EN to count completed packets
// on pkt_sent_o. Without it, pkt_sent_o is tied to zero.
module hermes_sender #(
    parameter int FLIT_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pkt_valid_i,
    output logic                 pkt_ready_o,
    input  logic [FLIT_SIZE-1:0] header_i,
    input  logic [FLIT_SIZE-1:0] size_i,
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 tx_o,
    output logic                 eop_o,
    output logic [FLIT_SIZE-1:0] data_o,
    input  logic                 credit_i,
    output logic                 busy_o,
    output logic [31:0]          pkt_sent_o
);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        HEADER  = 4'b0010,
        SIZE    = 4'b0100,
        PAYLOAD = 4'b1000
    } state_t;

    localparam logic [FLIT_SIZE-1:0] ONE = {{(FLIT_SIZE-1){1'b0}}, 1'b1};

    state_t               state;
    logic [FLIT_SIZE-1:0] hdr_q;
    logic [FLIT_SIZE-1:0] size_q;
    logic [FLIT_SIZE-1:0] rem_q;
    logic                 ready_q;
    logic                 xfer;

    // Link-side outputs decoded from the registered state; the payload path
    // is a pass-through so the source holds data_i while credit is low.
    always_comb begin
        tx_o         = 1'b0;
        eop_o        = 1'b0;
        data_o       = '0;
        data_ready_o = 1'b0;
        case (state)
            HEADER: begin
                tx_o   = 1'b1;
                data_o = hdr_q;
            end
            SIZE: begin
                tx_o   = 1'b1;
                data_o = size_q;
                eop_o  = (size_q == '0);
            end
            PAYLOAD: begin
                tx_o         = data_valid_i;
                data_o       = data_i;
                data_ready_o = credit_i;
                eop_o        = (rem_q == ONE);
            end
            default: ;
        endcase
    end

    assign xfer        = tx_o & credit_i;
    assign pkt_ready_o = ready_q;
    assign busy_o      = (state != IDLE);

    // Packet FSM; ready_q is registered so it stays low for the first cycle
    // after reset release and for the cycle a descriptor is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            ready_q <= 1'b0;
            hdr_q   <= '0;
            size_q  <= '0;
            rem_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (pkt_valid_i && ready_q) begin
                        hdr_q   <= header_i;
                        size_q  <= size_i;
                        ready_q <= 1'b0;
                        state   <= HEADER;
                    end
                end
                HEADER: begin
                    if (xfer) state <= SIZE;
                end
                SIZE: begin
                    if (xfer) begin
                        if (size_q == '0) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            rem_q <= size_q;
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    // rem_q is at least 1 here, so the decrement cannot wrap
                    if (xfer) begin
                        rem_q <= rem_q - ONE;
                        if (rem_q == ONE) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef HERMES_SENDER_STATS_EN
    logic [31:0] cnt_q;

    // Count packets whose last flit crossed the link, saturating at all-ones
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            cnt_q <= '0;
        else if (xfer && eop_o && !(&cnt_q))
            cnt_q <= cnt_q + 32'd1;
    end

    assign pkt_sent_o = cnt_q;
`else
    assign pkt_sent_o = '0;
`endif

endmodule
